// File: rtl/fpu_result_sign_resolve.sv
// Resolves the final IEEE-754 adder result sign, packs {sign, exp, man} and applies NaN/inf/zero overrides.
// Latency 2 cycles, 1/cycle throughput; elastic valid/ready, stage 1 holds while the output stalls.
// Optional sticky invalid flag when FPU_SIGN_STICKY_FLAGS_EN is defined.
`timescale 1ns/1ps
module fpu_result_sign_resolve #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef FPU_SIGN_STICKY_FLAGS_EN
  input  logic                   flag_clr,
  output logic                   invalid_sticky,
`endif
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   sign_big,
  input  logic                   add_path,
  input  logic                   mag_zero,
  input  logic                   a_is_inf,
  input  logic                   b_is_inf,
  input  logic                   any_nan,
  input  logic                   any_snan,
  input  logic [2:0]             rnd_mode,
  input  logic [EXP_W-1:0]       exp_in,
  input  logic [MAN_W-1:0]       man_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   invalid
);

  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic             r_s1_valid;
  logic             r_s1_sign_big;
  logic             r_s1_add_path;
  logic             r_s1_mag_zero;
  logic             r_s1_a_inf;
  logic             r_s1_b_inf;
  logic             r_s1_nan;
  logic             r_s1_snan;
  logic [2:0]       r_s1_rnd;
  logic [EXP_W-1:0] r_s1_exp;
  logic [MAN_W-1:0] r_s1_man;

  logic             r_out_valid;
  logic [W-1:0]     r_result;
  logic             r_invalid;

  logic             w_s1_move;
  logic             w_in_fire;
  logic [W-1:0]     w_res;
  logic             w_res_inv;

  assign w_s1_move = !r_out_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s1_move;
  assign w_in_fire = in_valid && in_ready;

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign invalid   = r_invalid;

  // First matching rule wins: NaN, inf-inf, single inf, cancellation, signed zero, normal.
  always_comb begin
    w_res     = {r_s1_sign_big, r_s1_exp, r_s1_man};
    w_res_inv = 1'b0;
    if (r_s1_nan) begin
      w_res     = QNAN;
      w_res_inv = r_s1_snan;
    end else if (r_s1_a_inf && r_s1_b_inf && !r_s1_add_path) begin
      w_res     = QNAN;
      w_res_inv = 1'b1;
    end else if (r_s1_a_inf || r_s1_b_inf) begin
      w_res = {r_s1_sign_big, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (r_s1_mag_zero && !r_s1_add_path) begin
      // Exact cancellation is +0 except when rounding toward -inf.
      w_res = {(r_s1_rnd == 3'b010), {(W-1){1'b0}}};
    end else if (r_s1_mag_zero) begin
      w_res = {r_s1_sign_big, {(W-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid    <= 1'b0;
      r_s1_sign_big <= 1'b0;
      r_s1_add_path <= 1'b0;
      r_s1_mag_zero <= 1'b0;
      r_s1_a_inf    <= 1'b0;
      r_s1_b_inf    <= 1'b0;
      r_s1_nan      <= 1'b0;
      r_s1_snan     <= 1'b0;
      r_s1_rnd      <= 3'b000;
      r_s1_exp      <= '0;
      r_s1_man      <= '0;
    end else begin
      if (in_ready) r_s1_valid <= in_valid;
      if (w_in_fire) begin
        r_s1_sign_big <= sign_big;
        r_s1_add_path <= add_path;
        r_s1_mag_zero <= mag_zero;
        r_s1_a_inf    <= a_is_inf;
        r_s1_b_inf    <= b_is_inf;
        r_s1_nan      <= any_nan;
        r_s1_snan     <= any_snan;
        r_s1_rnd      <= rnd_mode;
        r_s1_exp      <= exp_in;
        r_s1_man      <= man_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_invalid   <= 1'b0;
    end else if (w_s1_move) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result  <= w_res;
        r_invalid <= w_res_inv;
      end
    end
  end

`ifdef FPU_SIGN_STICKY_FLAGS_EN
  logic r_invalid_sticky;

  assign invalid_sticky = r_invalid_sticky;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_invalid_sticky <= 1'b0;
    end else if (r_out_valid && out_ready && r_invalid) begin
      r_invalid_sticky <= 1'b1;
    end else if (flag_clr) begin
      r_invalid_sticky <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_result_sign_resolve.sv
// Directed-vector bench for fpu_result_sign_resolve (single precision).
`timescale 1ns/1ps
module tb_fpu_result_sign_resolve;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign_big, add_path, mag_zero, a_is_inf, b_is_inf, any_nan, any_snan;
  logic [2:0]  rnd_mode;
  logic [7:0]  exp_in;
  logic [22:0] man_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        invalid;
`ifdef FPU_SIGN_STICKY_FLAGS_EN
  logic        flag_clr;
  logic        invalid_sticky;
`endif

  int checks = 0;
  int errors = 0;

  // flg = {sign_big, add_path, mag_zero, a_is_inf, b_is_inf, any_nan, any_snan}
  typedef struct packed {
    logic [6:0]  flg;
    logic [2:0]  rm;
    logic [7:0]  ex;
    logic [22:0] mn;
    logic [31:0] er;
    logic        ei;
  } vec_t;

  fpu_result_sign_resolve #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef FPU_SIGN_STICKY_FLAGS_EN
    .flag_clr       (flag_clr),
    .invalid_sticky (invalid_sticky),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_big  (sign_big),
    .add_path  (add_path),
    .mag_zero  (mag_zero),
    .a_is_inf  (a_is_inf),
    .b_is_inf  (b_is_inf),
    .any_nan   (any_nan),
    .any_snan  (any_snan),
    .rnd_mode  (rnd_mode),
    .exp_in    (exp_in),
    .man_in    (man_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .invalid   (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_vec(input vec_t v);
    {sign_big, add_path, mag_zero, a_is_inf, b_is_inf, any_nan, any_snan} = v.flg;
    rnd_mode = v.rm;
    exp_in   = v.ex;
    man_in   = v.mn;
  endtask

  // One accept then wait for the result to reach stage 2; leaves out_valid showing it.
  task automatic drive_one(input vec_t v);
    set_vec(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] b2b_exp(input int i);
    logic [7:0]  e;
    logic [22:0] m;
    logic        s;
    e = 8'h10 + 8'(i);
    m = 23'(i + 1) << 12;
    s = (i % 2) == 1;
    return {s, e, m};
  endfunction

  task automatic test_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0 || invalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b result=%h invalid=%b, want 0/00000000/0", out_valid, result, invalid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    set_vec('{flg: 7'b1100000, rm: 3'b000, ex: 8'h80, mn: 23'h400000, er: 32'h0, ei: 1'b0});
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency_early: out_valid=%b after 1 cycle, want 0", out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || result !== 32'hC0400000 || invalid !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got valid=%b result=%h invalid=%b, want 1/C0400000/0", out_valid, result, invalid);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_no_dup: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_cancel();
    vec_t t[6];
    t[0] = '{flg: 7'b0010000, rm: 3'b000, ex: 8'h55, mn: 23'h123, er: 32'h00000000, ei: 1'b0};
    t[1] = '{flg: 7'b0010000, rm: 3'b010, ex: 8'h55, mn: 23'h123, er: 32'h80000000, ei: 1'b0};
    t[2] = '{flg: 7'b1010000, rm: 3'b011, ex: 8'h55, mn: 23'h123, er: 32'h00000000, ei: 1'b0};
    t[3] = '{flg: 7'b1010000, rm: 3'b101, ex: 8'h55, mn: 23'h123, er: 32'h00000000, ei: 1'b0};
    t[4] = '{flg: 7'b1110000, rm: 3'b010, ex: 8'h55, mn: 23'h123, er: 32'h80000000, ei: 1'b0};
    t[5] = '{flg: 7'b0110000, rm: 3'b010, ex: 8'h55, mn: 23'h123, er: 32'h00000000, ei: 1'b0};
    for (int i = 0; i < 6; i++) begin
      drive_one(t[i]);
      checks++;
      if (out_valid !== 1'b1 || result !== t[i].er || invalid !== t[i].ei) begin
        errors++;
        $display("FAIL cancel[%0d]: got valid=%b result=%h invalid=%b, want 1/%h/%b", i, out_valid, result, invalid, t[i].er, t[i].ei);
      end
    end
  endtask

  task automatic test_inf();
    vec_t t[4];
    t[0] = '{flg: 7'b0001100, rm: 3'b000, ex: 8'h12, mn: 23'h5, er: 32'h7FC00000, ei: 1'b1};
    t[1] = '{flg: 7'b1101100, rm: 3'b000, ex: 8'h12, mn: 23'h5, er: 32'hFF800000, ei: 1'b0};
    t[2] = '{flg: 7'b0000100, rm: 3'b000, ex: 8'h12, mn: 23'h5, er: 32'h7F800000, ei: 1'b0};
    t[3] = '{flg: 7'b1011000, rm: 3'b010, ex: 8'h12, mn: 23'h5, er: 32'hFF800000, ei: 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive_one(t[i]);
      checks++;
      if (out_valid !== 1'b1 || result !== t[i].er || invalid !== t[i].ei) begin
        errors++;
        $display("FAIL inf[%0d]: got valid=%b result=%h invalid=%b, want 1/%h/%b", i, out_valid, result, invalid, t[i].er, t[i].ei);
      end
    end
  endtask

  task automatic test_nan();
    vec_t t[3];
    t[0] = '{flg: 7'b0000011, rm: 3'b000, ex: 8'h33, mn: 23'h77, er: 32'h7FC00000, ei: 1'b1};
    t[1] = '{flg: 7'b1100010, rm: 3'b000, ex: 8'h33, mn: 23'h77, er: 32'h7FC00000, ei: 1'b0};
    t[2] = '{flg: 7'b1001110, rm: 3'b000, ex: 8'h33, mn: 23'h77, er: 32'h7FC00000, ei: 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive_one(t[i]);
      checks++;
      if (out_valid !== 1'b1 || result !== t[i].er || invalid !== t[i].ei) begin
        errors++;
        $display("FAIL nan[%0d]: got valid=%b result=%h invalid=%b, want 1/%h/%b", i, out_valid, result, invalid, t[i].er, t[i].ei);
      end
    end
  endtask

  task automatic test_back_to_back();
    int   nin  = 0;
    int   nout = 0;
    logic in_fire, out_fire;
    // Drain any result left over from earlier tests.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 40 && nout < 4; c++) begin
      out_ready = (c >= 5);
      in_valid  = (nin < 4);
      set_vec('{flg: {((nin % 2) == 1), 1'b1, 5'b0}, rm: 3'b000, ex: 8'h10 + 8'(nin),
                mn: 23'(nin + 1) << 12, er: 32'h0, ei: 1'b0});
      #1;
      if (c == 2) begin
        checks++;
        if (in_ready !== 1'b0 || nin != 2) begin
          errors++;
          $display("FAIL b2b_ready_drop: in_ready=%b accepts=%0d, want 0/2", in_ready, nin);
        end
      end
      if (out_valid && !out_ready) begin
        checks++;
        if (result !== b2b_exp(nout)) begin
          errors++;
          $display("FAIL b2b_stall_stable: got %h want %h", result, b2b_exp(nout));
        end
      end
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        checks++;
        if (result !== b2b_exp(nout) || invalid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_order[%0d]: got %h/%b want %h/0", nout, result, invalid, b2b_exp(nout));
        end
        nout++;
      end
      @(posedge clk); #1;
      if (in_fire) nin++;
    end
    in_valid = 1'b0;
    checks++;
    if (nout != 4 || nin != 4) begin
      errors++;
      $display("FAIL b2b_count: popped %0d pushed %0d, want 4/4", nout, nin);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_dup: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    set_vec('{flg: 7'b0000011, rm: 3'b000, ex: 8'h01, mn: 23'h1, er: 32'h0, ei: 1'b0});
    out_ready = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || invalid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_full: valid=%b in_ready=%b invalid=%b, want 1/0/1", out_valid, in_ready, invalid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0 || invalid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear: valid=%b result=%h invalid=%b, want 0/00000000/0", out_valid, result, invalid);
    end
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ready: in_ready=%b want 1", in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midrst_stale[%0d]: out_valid=%b want 0", i, out_valid);
      end
    end
  endtask

`ifdef FPU_SIGN_STICKY_FLAGS_EN
  task automatic test_sticky();
    vec_t v;
    v = '{flg: 7'b0000011, rm: 3'b000, ex: 8'h0, mn: 23'h0, er: 32'h0, ei: 1'b0};
    drive_one(v);
    checks++;
    if (invalid_sticky !== 1'b0) begin
      errors++;
      $display("FAIL sticky_before_pop: got %b want 0", invalid_sticky);
    end
    @(posedge clk); #1;
    checks++;
    if (invalid_sticky !== 1'b1) begin
      errors++;
      $display("FAIL sticky_set: got %b want 1", invalid_sticky);
    end
    flag_clr = 1'b1;
    @(posedge clk); #1;
    flag_clr = 1'b0;
    checks++;
    if (invalid_sticky !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clr: got %b want 0", invalid_sticky);
    end
    drive_one(v);
    flag_clr = 1'b1;
    @(posedge clk); #1;
    flag_clr = 1'b0;
    checks++;
    if (invalid_sticky !== 1'b1) begin
      errors++;
      $display("FAIL sticky_set_wins: got %b want 1", invalid_sticky);
    end
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_vec('{flg: 7'b0, rm: 3'b000, ex: 8'h0, mn: 23'h0, er: 32'h0, ei: 1'b0});
`ifdef FPU_SIGN_STICKY_FLAGS_EN
    flag_clr = 1'b0;
`endif
    test_reset();
    test_basic();
    test_cancel();
    test_inf();
    test_nan();
    test_back_to_back();
    test_reset_midflight();
`ifdef FPU_SIGN_STICKY_FLAGS_EN
    test_sticky();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
